// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address window, the instruction loaded for
// bubbles and faults, and the fetch-unit state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FULL,
        ST_ERR
    } fetch_state_e;

    // A fetch address is illegal when misaligned or outside [lo, hi].
    function automatic logic pc_illegal(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word or a bubble when enabled,
// otherwise holds its contents.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        adel_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        adel_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_o <= NOP_INSTR;
            pc_o    <= '0;
            valid_o <= 1'b0;
            adel_o  <= 1'b0;
        end else if (en_i) begin
            if (bubble_i) begin
                instr_o <= NOP_INSTR;
                pc_o    <= '0;
                valid_o <= 1'b0;
                adel_o  <= 1'b0;
            end else begin
                instr_o <= instr_i;
                pc_o    <= pc_i;
                valid_o <= 1'b1;
                adel_o  <= adel_i;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory handshake, one-entry skid
// buffer for stalls, pending-redirect latch, and the IF/ID register.
//
//   state | meaning
//   IDLE  | first cycle after reset, no request
//   WAIT  | request outstanding at pc_f
//   FULL  | fetched word parked in skid buffer while D is stalled
//   ERR   | pc_f illegal; D receives fault markers until redirected
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [31:0] IMEM_LIMIT = cpu_pkg::IMEM_LIMIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     npc_in,
    input  logic            npc_sel,
    input  logic            stall_d,
    if_fetch_unit_if.master imem,
    output logic [31:0]     pc_f,
    output logic [31:0]     instr_d,
    output logic [31:0]     pc_d,
    output logic            valid_d,
    output logic            adel_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic         tgt_pend_q, tgt_pend_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  skid_q, skid_d;

    logic         req_c;
    logic         d_en, d_bubble, d_adel;
    logic [31:0]  d_instr, d_pc;

    logic         redir;
    logic [31:0]  npc;

    // A redirect only counts when D holds a real, advancing instruction.
    assign redir = npc_sel & valid_d & ~stall_d;
    assign npc   = redir      ? npc_in :
                   tgt_pend_q ? tgt_q  : pc_f_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_f_q     <= RESET_PC;
            tgt_pend_q <= 1'b0;
            tgt_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            tgt_pend_q <= tgt_pend_d;
            tgt_q      <= tgt_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        tgt_pend_d = tgt_pend_q;
        tgt_d      = tgt_q;
        skid_d     = skid_q;
        req_c      = 1'b0;
        d_en       = 1'b0;
        d_bubble   = 1'b0;
        d_instr    = imem.imem_rdata;
        d_pc       = pc_f_q;
        d_adel     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = pc_illegal(pc_f_q, RESET_PC, IMEM_LIMIT) ? ST_ERR : ST_WAIT;
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (imem.imem_ack) begin
                    if (!stall_d) begin
                        d_en       = 1'b1;
                        pc_f_d     = npc;
                        tgt_pend_d = 1'b0;
                        state_d    = pc_illegal(npc, RESET_PC, IMEM_LIMIT) ? ST_ERR : ST_WAIT;
                    end else begin
                        skid_d  = imem.imem_rdata;
                        state_d = ST_FULL;
                    end
                end else if (!stall_d) begin
                    d_en     = 1'b1;
                    d_bubble = 1'b1;
                    if (redir) begin
                        tgt_pend_d = 1'b1;
                        tgt_d      = npc_in;
                    end
                end
            end
            ST_FULL: begin
                // pc_f was not advanced on capture, so it is the skid word's PC.
                if (!stall_d) begin
                    d_en       = 1'b1;
                    d_instr    = skid_q;
                    pc_f_d     = npc;
                    tgt_pend_d = 1'b0;
                    state_d    = pc_illegal(npc, RESET_PC, IMEM_LIMIT) ? ST_ERR : ST_WAIT;
                end
            end
            ST_ERR: begin
                if (!stall_d) begin
                    d_en    = 1'b1;
                    d_instr = NOP_INSTR;
                    d_adel  = 1'b1;
                    if (redir) begin
                        pc_f_d     = npc_in;
                        tgt_pend_d = 1'b0;
                        state_d    = pc_illegal(npc_in, RESET_PC, IMEM_LIMIT) ? ST_ERR : ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc_f_q;
    assign pc_f           = pc_f_q;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (d_en),
        .bubble_i (d_bubble),
        .instr_i  (d_instr),
        .pc_i     (d_pc),
        .adel_i   (d_adel),
        .instr_o  (instr_d),
        .pc_o     (pc_d),
        .valid_o  (valid_d),
        .adel_o   (adel_d)
    );

endmodule
